// File: rtl/b_buff_reader_pkg.sv
// Shared types and constants for the B row-buffer read sequencer.
// Optional stall counter is enabled by B_BUFF_READER_STALL_CNT_EN.
package b_buff_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

    function automatic int width(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/b_buff_reader_skid.sv
// Two-entry FIFO absorbing the buffer's read latency.
// Entries carry {final, last, data}.
module b_rd_skid
    import b_buff_reader_pkg::*;
#(
    parameter int W  = 34,
    parameter int CW = width(SKID_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [SKID_DEPTH];
    logic [W-1:0]  mem_d [SKID_DEPTH];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) rd_d = ~rd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/b_buff_reader.sv
// Walks the B buffer rows for N passes and streams them to the PE array.
// Define B_BUFF_READER_STALL_CNT_EN to build the backpressure counter.
module b_buff_reader
    import b_buff_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MACS   = 4,
    parameter int NUM_ROWS   = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           num_passes,
    output logic                           busy,
    output logic                           done,
    output logic                           buf_en,
    output logic                           buf_wr,
    output logic [ADDR_WIDTH-1:0]          buf_addr,
    input  logic [NUM_MACS*DATA_WIDTH-1:0] buf_data,
    output logic [NUM_MACS*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           out_final,
    output logic [31:0]                    stall_cycles
);

    localparam int RW = NUM_MACS * DATA_WIDTH;
    localparam int CW = width(SKID_DEPTH + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d;
    logic [CNT_WIDTH-1:0]  passes_q, passes_d;
    logic                  inflight_q, inflight_d;
    logic                  tlast_q, tlast_d;
    logic                  tfinal_q, tfinal_d;
    logic                  done_q, done_d;

    logic [RW+1:0] head;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          pop, issue, last_row, last_pass;

    assign pop       = out_valid && out_ready;
    assign last_row  = row_q == ADDR_WIDTH'(NUM_ROWS - 1);
    assign last_pass = pass_q == passes_q - CNT_WIDTH'(1);

    // A slot freed by this cycle's pop counts as free, keeping 1 row/cycle.
    assign occ   = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue = (state_q == S_STREAM) && (occ < (CW+1)'(SKID_DEPTH));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        pass_d     = pass_q;
        passes_d   = passes_q;
        done_d     = 1'b0;
        inflight_d = issue;
        tlast_d    = last_row;
        tfinal_d   = last_row && last_pass;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_passes == '0) begin
                        done_d = 1'b1;
                    end else begin
                        passes_d = num_passes;
                        row_d    = '0;
                        pass_d   = '0;
                        state_d  = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (issue) begin
                    if (last_row) begin
                        row_d  = '0;
                        pass_d = pass_q + CNT_WIDTH'(1);
                        if (last_pass) state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head[RW+1]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            pass_q     <= '0;
            passes_q   <= '0;
            inflight_q <= 1'b0;
            tlast_q    <= 1'b0;
            tfinal_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            pass_q     <= pass_d;
            passes_q   <= passes_d;
            inflight_q <= inflight_d;
            tlast_q    <= tlast_d;
            tfinal_q   <= tfinal_d;
            done_q     <= done_d;
        end
    end

    b_rd_skid #(
        .W  (RW + 2),
        .CW (CW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({tfinal_q, tlast_q, buf_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign buf_en    = issue;
    assign buf_wr    = 1'b0;
    assign buf_addr  = row_q;
    assign out_valid = count != '0;
    assign out_data  = out_valid ? head[RW-1:0] : '0;
    assign out_last  = out_valid && head[RW];
    assign out_final = out_valid && head[RW+1];

`ifdef B_BUFF_READER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start)
            stall_d = '0;
        else if (out_valid && !out_ready && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_b_buff_reader.sv
// Directed bench for b_buff_reader with a beat-queue reference model.
module tb_b_buff_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_passes;
    logic        busy, done, buf_en, buf_wr;
    logic [2:0]  buf_addr;
    logic [31:0] buf_data;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last, out_final;
    logic [31:0] stall_cycles;

    b_buff_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_passes   (num_passes),
        .busy         (busy),
        .done         (done),
        .buf_en       (buf_en),
        .buf_wr       (buf_wr),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_final    (out_final),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        f;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rows[4];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc, first_en, first_valid, done_cyc;
    int          done_cnt, beats, last_seen, final_seen;
    int          en_seen, busy_seen, stall_exp;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        toggle = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          pidx = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (buf_en) buf_data <= rows[buf_addr[1:0]];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle ? pat[pidx % 4] : 1'b1;
            pidx++;
        end
    end

    // Reference checker: each valid beat must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            chk("buf_wr", buf_wr, 0);
            if (busy) busy_seen++;
            if (buf_en) begin
                en_seen++;
                if (first_en < 0) first_en = cyc;
            end
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("beat_data", out_data, exp_q[0].d);
                    chk("beat_last", out_last, exp_q[0].l);
                    chk("beat_final", out_final, exp_q[0].f);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                        if (out_last) last_seen++;
                        if (out_final) final_seen++;
                    end
                end
                if (!out_ready) stall_exp++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_queue_empty", exp_q.size(), 0);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_stats();
        first_en    = -1;
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        beats       = 0;
        last_seen   = 0;
        final_seen  = 0;
        en_seen     = 0;
        busy_seen   = 0;
        stall_exp   = 0;
    endtask

    task automatic pulse_start(input int n, input bit model);
        @(posedge clk);
        #1;
        if (model) begin
            clear_stats();
            exp_q.delete();
            for (int p = 0; p < n; p++)
                for (int r = 0; r < 4; r++)
                    exp_q.push_back('{rows[r], r == 3, (r == 3) && (p == n - 1)});
            start_cyc = cyc;
        end
        start      = 1'b1;
        num_passes = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stall();
`ifdef B_BUFF_READER_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stall_exp);
`else
        chk("stall_cycles", stall_cycles, 0);
`endif
    endtask

    initial begin
        for (int r = 0; r < 4; r++) rows[r] = 32'hA0A0A0A0 + r * 32'h01010101;
        rst        = 1'b0;
        start      = 1'b0;
        num_passes = '0;
        buf_data   = '0;
        clear_stats();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_final", out_final, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_cycles, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // single pass, ready held high
        pulse_start(1, 1);
        wait_done();
        chk("p1_first_en", first_en - start_cyc, 1);
        chk("p1_first_valid", first_valid - start_cyc, 3);
        chk("p1_done_cyc", done_cyc - start_cyc, 7);
        chk("p1_beats", beats, 4);
        chk("p1_done_cnt", done_cnt, 1);
        chk("p1_last_row", rows[3], 32'hA3A3A3A3);
        chk("p1_busy_after", busy, 0);

        // three passes
        pulse_start(3, 1);
        wait_done();
        chk("p3_beats", beats, 12);
        chk("p3_last_seen", last_seen, 3);
        chk("p3_final_seen", final_seen, 1);
        chk("p3_done_cyc", done_cyc - start_cyc, 15);
        chk("p3_done_cnt", done_cnt, 1);

        // two passes with backpressure
        toggle = 1'b1;
        pidx   = 0;
        pulse_start(2, 1);
        wait_done();
        toggle = 1'b0;
        chk("bp_beats", beats, 8);
        chk("bp_queue", exp_q.size(), 0);
        chk("bp_stalls_seen", stall_exp > 0, 1);
        chk("bp_done_cnt", done_cnt, 1);
        check_stall();

        // zero passes
        pulse_start(0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("z_done_cnt", done_cnt, 1);
        chk("z_done_cyc", done_cyc - start_cyc, 1);
        chk("z_buf_en", en_seen, 0);
        chk("z_busy", busy_seen, 0);

        // reset after two beats
        pulse_start(2, 1);
        begin
            int n;
            n = 0;
            while (beats < 2 && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("rst_mid_reach", beats >= 2, 1);
        end
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rmid_out_valid", out_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_buf_en", buf_en, 0);
        chk("rmid_done_cnt", done_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pulse_start(1, 1);
        wait_done();
        chk("rpost_beats", beats, 4);
        chk("rpost_done_cnt", done_cnt, 1);

        // start while busy is ignored
        pulse_start(2, 1);
        repeat (2) @(posedge clk);
        pulse_start(5, 0);
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("ign_beats", beats, 8);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_final_seen", final_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
